op_issue_queue: RTL and testbench
=================================

Name: op_issue_queue

Overview:
- Instruction front-end that sits directly upstream of the CKKS datapath core.
- Buffers `operation` words pushed by the host or testbench in a FIFO.
- Presents exactly one operation at a time on the core's `op` input and holds it stable until the core's `done_out` pulse.
- Inserts NO_OP drain cycles between operations, counts retired operations, and flags a per-operation watchdog timeout.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DRAIN_CYCLES, 2, cycles NO_OP is driven after each `done_out` before the next issue; ≥1.
- TIMEOUT_CYCLES, 4096, maximum cycles an operation may wait for `done_out` before `timeout_err` is set.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- push_valid  in  1  host offers an operation.
- push_op  in  $bits(operation)  operation word (mode, idx1_a, idx1_b, idx2_a, idx2_b, out_a, out_b).
- push_ready  out  1  FIFO can accept; high iff count < DEPTH.
- core_op  out  $bits(operation)  to core `op`.
- core_done  in  1  from core `done_out`.
- busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty.
- retired_cnt  out  CNT_W  number of completed operations; wraps modulo 2^CNT_W.
- timeout_err  out  1  sticky watchdog flag.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset values (reset==0 at posedge):
  - rd_ptr, wr_ptr, count cleared; state = IDLE.
  - core_op = NO_OP word with all index fields 0.
  - retired_cnt = 0; timeout_err = 0; wd_cnt = 0; drain_cnt = 0.
  - push_ready is 1 from the first cycle after reset.
  - Reset mid-operation discards all queued and in-flight ops with no retire.
- Push:
  - An entry is written when push_valid && push_ready.
  - Pushes while full are ignored; push_ready is low, so the host must hold the op.
- FIFO:
  - Registered storage; read data is the entry at rd_ptr.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - Push and pop in the same cycle are legal, including when full (count==DEPTH: pop frees the slot, but push_ready is still 0 that cycle, so no push occurs) and when empty (no pop possible).
- FSM:
  - IDLE:
    - core_op = NO_OP.
    - If count>0: register the head into core_op, pop, clear wd_cnt, go to ISSUE.
    - A push in the same cycle into an empty FIFO is not issued until the next cycle (1-cycle minimum push-to-issue latency beyond the write).
  - ISSUE:
    - core_op holds the op.
    - wd_cnt increments each cycle.
    - On core_done: retired_cnt+1; core_op = NO_OP; drain_cnt = DRAIN_CYCLES-1; go to DRAIN.
    - If wd_cnt reaches TIMEOUT_CYCLES-1 without core_done: set timeout_err, drive core_op = NO_OP, go to DRAIN without retiring.
    - A core_done arriving on that same cycle takes priority: retire, no error.
  - DRAIN:
    - core_op = NO_OP.
    - drain_cnt decrements each cycle.
    - At 0: if count>0, issue the head directly (as in IDLE) and go to ISSUE; else go to IDLE.
- core_op rules:
  - core_op is driven only from a register and is never combinational from the FIFO.
  - All fields are stable for the entire ISSUE interval, because the core reads source indices directly from `op` every cycle.
- Stray done: core_done while in IDLE or DRAIN is ignored; it does not retire or change state.
- Sticky flags: timeout_err is cleared only by reset; subsequent ops continue to issue normally.
- Issue timing: back-to-back ops see exactly DRAIN_CYCLES NO_OP cycles between core_done and the next op appearing on core_op.

Decomposition:
- Shared package (types.svh): the existing `operation` struct and `op_e` enum; add a localparam NO_OP_WORD (mode=NO_OP, indices 0).
- One natural sub-module: sync_fifo (parameterised WIDTH, DEPTH; push/pop/full/empty/count). It is reusable for later writeback queues.
- The FSM, watchdog and counters stay in op_issue_queue.

Test Plan:
- Single op: push one CT_CT_ADD (idx1_a=1, idx1_b=2, idx2_a=3, idx2_b=4, out_a=5, out_b=6); model done 3 cycles after issue → core_op equals the pushed word for exactly those cycles; retired_cnt=1; then NO_OP for 2 cycles; busy falls to 0.
- Back-to-back: push 3 ops (ADD, CT_PT_ADD, CT_PT_MUL) in consecutive cycles → issued in order, each separated by exactly 2 NO_OP cycles; retired_cnt=3.
- Full FIFO: with the core stalled, push 9 ops at DEPTH=8 → push_ready low after the 8th is accepted (count=8); a simultaneous pop/push at full leaves count correct; all ops are eventually issued in FIFO order.
- Watchdog: TIMEOUT_CYCLES=16, never assert core_done → timeout_err=1 on the 16th ISSUE cycle; retired_cnt unchanged; the next queued op issues after the drain.
- Reset mid-op: assert reset=0 during ISSUE with 4 ops queued → next cycle core_op=NO_OP, fifo_count=0, retired_cnt=0, timeout_err=0.
- Stray/wrap: pulse core_done while in IDLE → no change; CNT_W=4, retire 17 ops → retired_cnt=1.

Source files
------------

// File: rtl/op_issue_queue_pkg.sv
// rtl/op_issue_queue_pkg.sv - operation word, opcode enum and issue FSM states
package op_issue_queue_pkg;

   localparam int IDX_W = 4;

   typedef enum logic [2:0] {
      NO_OP     = 3'd0,
      CT_CT_ADD = 3'd1,
      CT_PT_ADD = 3'd2,
      CT_PT_MUL = 3'd3,
      CT_CT_MUL = 3'd4,
      RESCALE   = 3'd5
   } op_e;

   typedef struct packed {
      op_e              mode;
      logic [IDX_W-1:0] idx1_a;
      logic [IDX_W-1:0] idx1_b;
      logic [IDX_W-1:0] idx2_a;
      logic [IDX_W-1:0] idx2_b;
      logic [IDX_W-1:0] out_a;
      logic [IDX_W-1:0] out_b;
   } operation;

   localparam operation NO_OP_WORD = '{
      mode:   NO_OP,
      idx1_a: '0,
      idx1_b: '0,
      idx2_a: '0,
      idx2_b: '0,
      out_a:  '0,
      out_b:  '0
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } issue_state_e;

endpackage

// File: rtl/op_issue_queue_sync_fifo.sv
// rtl/op_issue_queue_sync_fifo.sv - synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign full     = (count_q == (PW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A full FIFO refuses the push even when a pop frees a slot this cycle.
   always_comb begin
      wr_en    = push && !full;
      rd_en    = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && wr_en) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/op_issue_queue.sv
// rtl/op_issue_queue.sv - buffers operations and issues them one at a time to the core
module op_issue_queue
   import op_issue_queue_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int DRAIN_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_valid,
   input  operation                 push_op,
   output logic                     push_ready,
   output operation                 core_op,
   input  logic                     core_done,
   output logic                     busy,
   output logic [CNT_W-1:0]         retired_cnt,
   output logic                     timeout_err,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int OP_W = $bits(operation);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

   issue_state_e     state_q, state_d;
   operation         core_op_q, core_op_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic [DR_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
   logic             timeout_err_q, timeout_err_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [OP_W-1:0]  fifo_rdata;

   sync_fifo #(
      .WIDTH (OP_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (reset),
      .push      (push_valid),
      .push_data (push_op),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign push_ready  = !fifo_full;
   assign core_op     = core_op_q;
   assign retired_cnt = retired_cnt_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;

   always_comb begin
      state_d       = state_q;
      core_op_d     = core_op_q;
      wd_cnt_d      = wd_cnt_q;
      drain_cnt_d   = drain_cnt_q;
      retired_cnt_d = retired_cnt_q;
      timeout_err_d = timeout_err_q;
      fifo_pop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            core_op_d = NO_OP_WORD;
            if (!fifo_empty) begin
               core_op_d = operation'(fifo_rdata);
               fifo_pop  = 1'b1;
               wd_cnt_d  = '0;
               state_d   = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            // done on the final watchdog cycle still counts as a clean retire
            if (core_done) begin
               retired_cnt_d = retired_cnt_q + 1'b1;
               core_op_d     = NO_OP_WORD;
               drain_cnt_d   = DR_W'(DRAIN_CYCLES - 1);
               state_d       = ST_DRAIN;
            end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_err_d = 1'b1;
               core_op_d     = NO_OP_WORD;
               drain_cnt_d   = DR_W'(DRAIN_CYCLES - 1);
               state_d       = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            core_op_d = NO_OP_WORD;
            if (drain_cnt_q == '0) begin
               if (!fifo_empty) begin
                  core_op_d = operation'(fifo_rdata);
                  fifo_pop  = 1'b1;
                  wd_cnt_d  = '0;
                  state_d   = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
         end

         default: begin
            core_op_d = NO_OP_WORD;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         core_op_q     <= NO_OP_WORD;
         wd_cnt_q      <= '0;
         drain_cnt_q   <= '0;
         retired_cnt_q <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         core_op_q     <= core_op_d;
         wd_cnt_q      <= wd_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         retired_cnt_q <= retired_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_op_issue_queue.sv
// tb/tb_op_issue_queue.sv - randomized bench with a timeline model of op issue
module tb_op_issue_queue;
   import op_issue_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int DRAIN = 2;
   localparam int TMO   = 16;
   localparam int CW    = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   push_valid;
   operation               push_op;
   logic                   push_ready;
   operation               core_op;
   logic                   core_done;
   logic                   busy;
   logic [CW-1:0]          retired_cnt;
   logic                   timeout_err;
   logic [$clog2(DEPTH):0] fifo_count;

   always #5 clk = ~clk;

   op_issue_queue #(
      .DEPTH          (DEPTH),
      .DRAIN_CYCLES   (DRAIN),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (push_valid),
      .push_op     (push_op),
      .push_ready  (push_ready),
      .core_op     (core_op),
      .core_done   (core_done),
      .busy        (busy),
      .retired_cnt (retired_cnt),
      .timeout_err (timeout_err),
      .fifo_count  (fifo_count)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Timeline model: an accepted op can appear no earlier than two cycles
   // after its push and no earlier than DRAIN+1 cycles after the previous
   // op finished (done or watchdog).
   typedef struct {
      operation op;
      int       p;
   } ent_t;

   ent_t     mq[$];
   operation src[$];
   bit       m_act;
   operation m_op;
   int       m_start, m_free, m_ret, cyc;
   bit       m_err;
   int       lat_cur, lat_min, lat_max, push_rate, stray_rate;

   function automatic operation rand_op();
      operation o;
      o.mode   = op_e'(3'($urandom_range(5, 1)));
      o.idx1_a = IDX_W'($urandom);
      o.idx1_b = IDX_W'($urandom);
      o.idx2_a = IDX_W'($urandom);
      o.idx2_b = IDX_W'($urandom);
      o.out_a  = IDX_W'($urandom);
      o.out_b  = IDX_W'($urandom);
      return o;
   endfunction

   function automatic operation mk(op_e m, int a, int b, int c, int d, int e, int f);
      operation o;
      o.mode   = m;
      o.idx1_a = IDX_W'(a);
      o.idx1_b = IDX_W'(b);
      o.idx2_a = IDX_W'(c);
      o.idx2_b = IDX_W'(d);
      o.out_a  = IDX_W'(e);
      o.out_b  = IDX_W'(f);
      return o;
   endfunction

   task automatic tick(input logic rst_n);
      ent_t e;
      reset      = rst_n;
      push_valid = (src.size() > 0) && ($urandom_range(99) < push_rate);
      push_op    = push_valid ? src[0] : rand_op();
      core_done  = m_act ? ((cyc - m_start) == lat_cur) : ($urandom_range(99) < stray_rate);
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         src.delete();
         m_act  = 1'b0;
         m_ret  = 0;
         m_err  = 1'b0;
         m_free = 0;
      end else begin
         if (m_act) begin
            if (core_done) begin
               m_ret++;
               m_act  = 1'b0;
               m_free = cyc + DRAIN + 1;
            end else if ((cyc - m_start) == TMO - 1) begin
               m_err  = 1'b1;
               m_act  = 1'b0;
               m_free = cyc + DRAIN + 1;
            end
         end
         if (push_valid && mq.size() < DEPTH) begin
            e.op = push_op;
            e.p  = cyc;
            mq.push_back(e);
            void'(src.pop_front());
         end
      end
      #1;
      cyc++;
      if (!m_act && mq.size() > 0 && cyc >= mq[0].p + 2 && cyc >= m_free) begin
         m_op = mq[0].op;
         void'(mq.pop_front());
         m_act   = 1'b1;
         m_start = cyc;
         lat_cur = $urandom_range(lat_max, lat_min);
      end
      chk("core_op", core_op, m_act ? m_op : NO_OP_WORD);
      chk("push_ready", push_ready, mq.size() < DEPTH);
      chk("fifo_count", fifo_count, mq.size());
      chk("busy", busy, m_act || mq.size() > 0 || cyc < m_free);
      chk("retired_cnt", retired_cnt, m_ret % (1 << CW));
      chk("timeout_err", timeout_err, m_err);
   endtask

   task automatic drain_all();
      int n = 0;
      while ((src.size() > 0 || m_act || mq.size() > 0 || cyc < m_free) && n < 3000) begin
         tick(1'b1);
         n++;
      end
      chk("drain_bound", n < 3000, 1);
   endtask

   initial begin
      int n;
      reset      = 1'b0;
      push_valid = 1'b0;
      push_op    = NO_OP_WORD;
      core_done  = 1'b0;
      cyc        = 0;
      m_act      = 1'b0;
      m_start    = 0;
      m_free     = 0;
      m_ret      = 0;
      m_err      = 1'b0;
      lat_cur    = 0;
      lat_min    = 2;
      lat_max    = 2;
      push_rate  = 100;
      stray_rate = 0;

      tick(1'b0);
      tick(1'b0);
      chk("rst_core_op", core_op, NO_OP_WORD);
      chk("rst_ready", push_ready, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);

      // single op, done on the third issue cycle
      src.push_back(mk(CT_CT_ADD, 1, 2, 3, 4, 5, 6));
      drain_all();
      chk("single_retired", retired_cnt, 1);
      chk("single_busy", busy, 0);

      // back-to-back
      lat_min = 0;
      lat_max = 3;
      src.push_back(mk(CT_CT_ADD, 7, 8, 9, 10, 11, 12));
      src.push_back(mk(CT_PT_ADD, 1, 3, 5, 7, 9, 11));
      src.push_back(mk(CT_PT_MUL, 2, 4, 6, 8, 10, 12));
      drain_all();
      chk("b2b_retired", retired_cnt, 4);

      // stalled core fills the FIFO
      lat_min = 14;
      lat_max = 14;
      for (int i = 0; i < 12; i++) src.push_back(rand_op());
      for (int i = 0; i < 10; i++) tick(1'b1);
      chk("full_count", fifo_count, 8);
      chk("full_ready", push_ready, 0);
      drain_all();
      chk("full_retired", retired_cnt, 0);

      // watchdog: core never answers
      lat_min = 20;
      lat_max = 20;
      src.push_back(rand_op());
      src.push_back(rand_op());
      drain_all();
      chk("wd_err", timeout_err, 1);
      chk("wd_retired", retired_cnt, 0);

      // reset while issuing with four queued
      for (int i = 0; i < 5; i++) src.push_back(rand_op());
      n = 0;
      while (!(m_act && mq.size() == 4) && n < 50) begin
         tick(1'b1);
         n++;
      end
      chk("rst_mid_reach", n < 50, 1);
      tick(1'b0);
      chk("rst_mid_core_op", core_op, NO_OP_WORD);
      chk("rst_mid_count", fifo_count, 0);
      chk("rst_mid_retired", retired_cnt, 0);
      chk("rst_mid_err", timeout_err, 0);

      // stray done in idle
      stray_rate = 100;
      for (int i = 0; i < 3; i++) tick(1'b1);
      stray_rate = 0;
      chk("stray_retired", retired_cnt, 0);
      chk("stray_busy", busy, 0);

      // counter wrap
      lat_min = 0;
      lat_max = 5;
      for (int i = 0; i < 17; i++) src.push_back(rand_op());
      drain_all();
      chk("wrap17", retired_cnt, 1);

      // random traffic
      lat_min    = 0;
      lat_max    = 20;
      push_rate  = 70;
      stray_rate = 10;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 30 && src.size() < 4) src.push_back(rand_op());
         tick($urandom_range(499) != 0);
      end
      stray_rate = 0;
      drain_all();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
